// File: rtl/seq_generator_if.sv
// seq_generator_if -- load handshake and serial output bundle for seq_generator.
//
// Signals:
//   load_valid  pattern offer (master -> generator)
//   load_data   8-bit pattern, sent MSB-first from bit load_len
//   load_len    pattern length minus one (0..7 -> 1..8 bits)
//   load_ready  generator is idle and will take a pattern
//   stop        end-of-loop request (only meaningful in loop builds)
//   x           serial bit stream
//   x_valid     high while a bit is being driven on x
//   done        one-cycle pulse at the end of a pass
//
// Modports: master = pattern source / stream consumer, slave = generator.
interface seq_generator_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic [2:0] load_len;
  logic       load_ready;
  logic       stop;
  logic       x;
  logic       x_valid;
  logic       done;

  modport master (
    output load_valid, load_data, load_len, stop,
    input  load_ready, x, x_valid, done
  );

  modport slave (
    input  load_valid, load_data, load_len, stop,
    output load_ready, x, x_valid, done
  );
endinterface

// File: rtl/seq_generator.sv
// seq_generator -- serialises a 1..8 bit pattern for a sequence detector,
// holding each bit DIV clock cycles and showing the current bit index on an
// active-low 7-segment display.
//
// Parameters:
//   DIV   clk cycles each serial bit is held (1 .. 2^25-1)
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   bus        seq_generator_if.slave (load handshake, stop, x/x_valid/done)
//   a..g       active-low 7-segment display of the bit index (blank when idle)
//
// Build option:
//   SEQGEN_LOOP_EN  when defined, the pattern repeats with no idle gap and a
//                   done pulse per pass; the run ends after the pass in which
//                   stop was seen high. When undefined, stop is ignored and
//                   every load produces exactly one pass.
//
// All outputs come straight from flops.
module seq_generator #(
  parameter int DIV = 20000000
) (
  input  logic           clk,
  input  logic           rst,
  seq_generator_if.slave bus,
  output logic           a,
  output logic           b,
  output logic           c,
  output logic           d,
  output logic           e,
  output logic           f,
  output logic           g
);

  // DIV=1 still needs a 1-bit counter so the compare against DIV-1 is legal.
  localparam int             CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [6:0]     SEG_BLANK = 7'b111_1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [7:0]       data_r;
  logic [2:0]       len_r;
  logic [2:0]       idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic             x_r;
  logic             x_valid_r;
  logic             done_r;
  logic             load_ready_r;
  logic [6:0]       seg_r;

  logic             last_tick_s;
  logic             last_bit_s;
  logic [2:0]       idx_next_s;
  logic             finish_s;

`ifdef SEQGEN_LOOP_EN
  logic             stop_seen_r;
`else
  logic             unused_stop_s;
`endif

  // Active-low {a,b,c,d,e,f,g} pattern for one index digit.
  function automatic logic [6:0] seg_decode(input logic [2:0] digit);
    logic [6:0] seg;
    case (digit)
      3'd0:    seg = 7'b000_0001;
      3'd1:    seg = 7'b100_1111;
      3'd2:    seg = 7'b001_0010;
      3'd3:    seg = 7'b000_0110;
      3'd4:    seg = 7'b100_1100;
      3'd5:    seg = 7'b010_0100;
      3'd6:    seg = 7'b010_0000;
      3'd7:    seg = 7'b000_1111;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Bit sent at a given index: MSB-first, starting from bit len.
  function automatic logic pattern_bit(input logic [7:0] data,
                                       input logic [2:0] len,
                                       input logic [2:0] idx);
    logic [2:0] pos;
    pos = len - idx;
    return data[pos];
  endfunction

  // Per-cycle bit timing decodes used by the SEND state.
  always_comb begin
    last_tick_s = (cnt_r == CNT_MAX);
    last_bit_s  = (idx_r == len_r);
    idx_next_s  = idx_r + 3'd1;
  end

`ifdef SEQGEN_LOOP_EN
  // A pass ends the run only if stop was seen during it (including its final edge).
  assign finish_s = stop_seen_r | bus.stop;
`else
  // Without looping every pass is the last one.
  assign finish_s = 1'b1;
  assign unused_stop_s = bus.stop;
`endif

  // Main FSM: pattern capture, bit timing, and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      data_r       <= 8'h00;
      len_r        <= 3'd0;
      idx_r        <= 3'd0;
      cnt_r        <= '0;
      x_r          <= 1'b0;
      x_valid_r    <= 1'b0;
      done_r       <= 1'b0;
      load_ready_r <= 1'b1;
      seg_r        <= SEG_BLANK;
`ifdef SEQGEN_LOOP_EN
      stop_seen_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.load_valid && load_ready_r) begin
            data_r       <= bus.load_data;
            len_r        <= bus.load_len;
            idx_r        <= 3'd0;
            cnt_r        <= '0;
            x_r          <= pattern_bit(bus.load_data, bus.load_len, 3'd0);
            x_valid_r    <= 1'b1;
            load_ready_r <= 1'b0;
            seg_r        <= seg_decode(3'd0);
            state_r      <= SEND;
`ifdef SEQGEN_LOOP_EN
            stop_seen_r  <= 1'b0;
`endif
          end else begin
            x_r          <= 1'b0;
            x_valid_r    <= 1'b0;
            load_ready_r <= 1'b1;
            seg_r        <= SEG_BLANK;
          end
        end

        SEND: begin
          done_r <= 1'b0;
`ifdef SEQGEN_LOOP_EN
          stop_seen_r <= stop_seen_r | bus.stop;
`endif
          if (last_tick_s) begin
            cnt_r <= '0;
            if (last_bit_s && finish_s) begin
              state_r   <= DONE;
              idx_r     <= 3'd0;
              x_r       <= 1'b0;
              x_valid_r <= 1'b0;
              done_r    <= 1'b1;
              seg_r     <= SEG_BLANK;
            end else if (last_bit_s) begin
              // Loop restart: pulse done alongside the first bit of the next pass.
              idx_r     <= 3'd0;
              x_r       <= pattern_bit(data_r, len_r, 3'd0);
              done_r    <= 1'b1;
              seg_r     <= seg_decode(3'd0);
`ifdef SEQGEN_LOOP_EN
              stop_seen_r <= 1'b0;
`endif
            end else begin
              idx_r <= idx_next_s;
              x_r   <= pattern_bit(data_r, len_r, idx_next_s);
              seg_r <= seg_decode(idx_next_s);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        DONE: begin
          state_r      <= IDLE;
          done_r       <= 1'b0;
          x_r          <= 1'b0;
          x_valid_r    <= 1'b0;
          load_ready_r <= 1'b1;
          seg_r        <= SEG_BLANK;
        end

        default: begin
          state_r      <= IDLE;
          idx_r        <= 3'd0;
          cnt_r        <= '0;
          done_r       <= 1'b0;
          x_r          <= 1'b0;
          x_valid_r    <= 1'b0;
          load_ready_r <= 1'b1;
          seg_r        <= SEG_BLANK;
        end
      endcase
    end
  end

  assign bus.load_ready      = load_ready_r;
  assign bus.x               = x_r;
  assign bus.x_valid         = x_valid_r;
  assign bus.done            = done_r;
  assign {a, b, c, d, e, f, g} = seg_r;

endmodule

// File: tb/tb_seq_generator.sv
// tb_seq_generator -- self-checking bench for seq_generator.
// Four generators (DIV = 1, 2, 3, 4) share clk/rst; one is exercised at a time.
// Expected per-cycle outputs are queued when a load is driven and popped and
// compared on each falling edge afterwards.
module tb_seq_generator;

  typedef struct packed {
    logic       x;
    logic       xv;
    logic       dn;
    logic       lr;
    logic [6:0] seg;
  } obs_t;

  typedef struct {
    int         k;
    logic [7:0] data;
    logic [2:0] len;
    logic [7:0] exp_bits;
    int         nbits;
  } vec_t;

  localparam logic [6:0] BLANK = 7'b111_1111;

  logic [6:0]      seg_ref [8];
  logic            clk;
  logic            rst;
  logic [3:0]      lv, stp, xo, xvo, dno, lro;
  logic [3:0][7:0] ld;
  logic [3:0][2:0] ll;
  logic [3:0][6:0] sgp;
  obs_t            exp_q[$];
  int              n_tests;
  int              n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : gen_dut
    seq_generator_if bus_if ();
    logic sa, sb, sc, sd, se, sf, sg;
    assign bus_if.load_valid = lv[gi];
    assign bus_if.load_data  = ld[gi];
    assign bus_if.load_len   = ll[gi];
    assign bus_if.stop       = stp[gi];
    assign xo[gi]  = bus_if.x;
    assign xvo[gi] = bus_if.x_valid;
    assign dno[gi] = bus_if.done;
    assign lro[gi] = bus_if.load_ready;
    assign sgp[gi] = {sa, sb, sc, sd, se, sf, sg};
    seq_generator #(.DIV(gi + 1)) dut (
      .clk(clk), .rst(rst), .bus(bus_if.slave),
      .a(sa), .b(sb), .c(sc), .d(sd), .e(se), .f(sf), .g(sg)
    );
  end

  function automatic obs_t mk(input logic x, input logic xv, input logic dn,
                              input logic lr, input logic [6:0] seg);
    obs_t o;
    o.x = x; o.xv = xv; o.dn = dn; o.lr = lr; o.seg = seg;
    return o;
  endfunction

  function automatic obs_t actual(input int k);
    return mk(xo[k], xvo[k], dno[k], lro[k], sgp[k]);
  endfunction

  task automatic cmp(input string name, input int idx, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got x=%b xv=%b done=%b rdy=%b seg=%b, want x=%b xv=%b done=%b rdy=%b seg=%b",
               name, idx, act.x, act.xv, act.dn, act.lr, act.seg,
               exp.x, exp.xv, exp.dn, exp.lr, exp.seg);
    end
  endtask

  task automatic push_bit(input int k, input logic b, input int idx, input logic first_done);
    for (int c = 0; c < k + 1; c++)
      exp_q.push_back(mk(b, 1'b1, first_done && (c == 0), 1'b0, seg_ref[idx]));
  endtask

  task automatic push_pass(input int k, input logic [7:0] bits, input int n, input logic first_done);
    for (int i = 0; i < n; i++)
      push_bit(k, bits[7-i], i, first_done && (i == 0));
  endtask

  task automatic push_end();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, BLANK));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, BLANK));
  endtask

  task automatic start_load(input int k, input logic [7:0] data, input logic [2:0] len);
    int w;
    @(negedge clk);
    w = 0;
    while (!lro[k] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!lro[k]) begin
      n_tests++;
      n_fail++;
      $display("FAIL load_ready_wait: dut%0d got 0 want 1", k);
    end
    lv[k] = 1'b1;
    ld[k] = data;
    ll[k] = len;
    @(posedge clk);
  endtask

  task automatic check_run(input string name, input int k, input int drop_at,
                           input int stop_at, input int chg_at,
                           input logic [7:0] nd, input logic [2:0] nl);
    int   cnt = 0;
    obs_t e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      cmp(name, cnt, actual(k), e);
      if (cnt == drop_at) lv[k] = 1'b0;
      if (cnt == chg_at) begin
        ld[k] = nd;
        ll[k] = nl;
      end
      if (cnt == stop_at) stp[k] = 1'b1;
      else stp[k] = 1'b0;
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    seg_ref[0] = 7'b000_0001; seg_ref[1] = 7'b100_1111;
    seg_ref[2] = 7'b001_0010; seg_ref[3] = 7'b000_0110;
    seg_ref[4] = 7'b100_1100; seg_ref[5] = 7'b010_0100;
    seg_ref[6] = 7'b010_0000; seg_ref[7] = 7'b000_1111;
    // {dut (DIV-1), data, len, expected bits MSB-aligned, bit count}
    vecs[0] = '{3, 8'h0A, 3'd3, 8'hA0, 4};  // DIV=4, 1010
    vecs[1] = '{0, 8'hA5, 3'd7, 8'hA5, 8};  // DIV=1, full byte
    vecs[2] = '{1, 8'h01, 3'd0, 8'h80, 1};  // DIV=2, single bit
    vecs[3] = '{2, 8'h3C, 3'd5, 8'hF0, 6};  // DIV=3, 111100
    vecs[4] = '{3, 8'hF5, 3'd2, 8'hA0, 3};  // DIV=4, upper bits ignored
    vecs[5] = '{0, 8'h02, 3'd1, 8'h80, 2};  // DIV=1, 10
    vecs[6] = '{1, 8'hF0, 3'd7, 8'hF0, 8};  // DIV=2, 11110000

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    lv  = 4'h0;
    stp = 4'h0;
    ld  = '0;
    ll  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      cmp("reset", k, actual(k), mk(1'b0, 1'b0, 1'b0, 1'b1, BLANK));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      start_load(vecs[i].k, vecs[i].data, vecs[i].len);
      push_pass(vecs[i].k, vecs[i].exp_bits, vecs[i].nbits, 1'b0);
      push_end();
      check_run($sformatf("vec%0d", i), vecs[i].k, 0, -1, -1, 8'h00, 3'd0);
    end

    // load_valid held through SEND with new data: first pass intact, second taken in IDLE
    start_load(2, 8'h0A, 3'd3);
    push_pass(2, 8'hA0, 4, 1'b0);
    push_end();
    push_pass(2, 8'hFF, 8, 1'b0);
    push_end();
    check_run("hold_valid", 2, 14, -1, 0, 8'hFF, 3'd7);

    // reset during the second bit aborts with no done pulse
    start_load(3, 8'h0A, 3'd3);
    push_bit(3, 1'b1, 0, 1'b0);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, seg_ref[1]));
    check_run("rst_mid_pre", 3, 0, -1, -1, 8'h00, 3'd0);
    rst = 1'b1;
    @(negedge clk);
    cmp("rst_abort", 0, actual(3), mk(1'b0, 1'b0, 1'b0, 1'b1, BLANK));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmp("rst_idle", i, actual(3), mk(1'b0, 1'b0, 1'b0, 1'b1, BLANK));
    end

`ifdef SEQGEN_LOOP_EN
    // continuous 1010 passes; stop raised mid pass 3 ends after pass 3
    start_load(1, 8'h0A, 3'd3);
    for (int p = 0; p < 3; p++)
      push_pass(1, 8'hA0, 4, p > 0);
    push_end();
    check_run("loop_stop", 1, 0, 20, -1, 8'h00, 3'd0);
`else
    // stop has no effect: exactly one pass
    start_load(1, 8'h0A, 3'd3);
    push_pass(1, 8'hA0, 4, 1'b0);
    push_end();
    check_run("stop_ignored", 1, 0, 4, -1, 8'h00, 3'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
